// File: rtl/mips32_mc_ctrl.sv
// Multicycle MIPS32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// timeout handling, overflow-suppressed writeback and a retired-instruction counter.
module mips32_mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  input  logic        overflow,
  input  logic        cond_true,
  output logic [2:0]  state,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [3:0]  rd_byte_w_en,
  output logic        bus_err,
  output logic        illegal,
  output logic        ovf_trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q, instret_d;

  logic       legal, timeout, retire, is_store, ovf_op;
  logic       pc_we_c, ir_we_c, mem_req_c, mem_we_c, addr_sel_c;
  logic       bus_err_c, illegal_c, ovf_trap_c;
  logic [1:0] pc_src_c;
  logic [3:0] rbe_c;

  always_comb begin
    case (opcode)
      6'h00, 6'h02, 6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23, 6'h2B: legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  assign timeout  = (wait_q == WAIT_LAST) && !mem_ready;
  assign is_store = (opcode == 6'h2B);
  assign ovf_op   = (opcode == 6'h08) ||
                    ((opcode == 6'h00) && ((funct == 6'h20) || (funct == 6'h22)));

  always_comb begin
    state_d    = S_FETCH;
    retire     = 1'b0;
    pc_we_c    = 1'b0;
    pc_src_c   = 2'd0;
    ir_we_c    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    rbe_c      = 4'b0000;
    bus_err_c  = 1'b0;
    illegal_c  = 1'b0;
    ovf_trap_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else begin
          // Timeout re-fetches the same PC, so state stays FETCH either way.
          bus_err_c = timeout;
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
        else       illegal_c = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          6'h02: begin
            pc_we_c  = 1'b1;
            pc_src_c = 2'd2;
            retire   = 1'b1;
          end
          6'h04, 6'h05: begin
            pc_we_c  = cond_true;
            pc_src_c = 2'd1;
            retire   = 1'b1;
          end
          6'h23, 6'h2B: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = is_store;
        if (mem_ready) begin
          if (is_store) retire = 1'b1;
          else          state_d = S_WB;
        end else if (timeout) begin
          bus_err_c = 1'b1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        retire = 1'b1;
        if (ovf_op && overflow) ovf_trap_c = 1'b1;
        else                    rbe_c = 4'b1111;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_d = 8'd0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && !timeout &&
        (state_d == state_q))
      wait_d = wait_q + 8'd1;
  end

  assign instret_d = instret_q + {31'd0, retire};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Gate with reset so an assertion mid-request drops outputs without waiting for an edge.
  assign state        = state_q;
  assign pc_we        = reset & pc_we_c;
  assign pc_src       = reset ? pc_src_c : 2'd0;
  assign ir_we        = reset & ir_we_c;
  assign mem_req      = reset & mem_req_c;
  assign mem_we       = reset & mem_we_c;
  assign mem_addr_sel = reset & addr_sel_c;
  assign rd_byte_w_en = reset ? rbe_c : 4'b0000;
  assign bus_err      = reset & bus_err_c;
  assign illegal      = reset & illegal_c;
  assign ovf_trap     = reset & ovf_trap_c;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mips32_mc_ctrl.sv
// Scoreboard bench for mips32_mc_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs; a monitor pops and compares.
module tb_mips32_mc_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        mem_ready, overflow, cond_true;
  logic [2:0]  state;
  logic        pc_we, ir_we, mem_req, mem_we, mem_addr_sel;
  logic [1:0]  pc_src;
  logic [3:0]  rd_byte_w_en;
  logic        bus_err, illegal, ovf_trap;
  logic [31:0] instret;

  mips32_mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .overflow(overflow), .cond_true(cond_true),
    .state(state), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .rd_byte_w_en(rd_byte_w_en), .bus_err(bus_err), .illegal(illegal),
    .ovf_trap(ovf_trap), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we, mem_req, mem_we, mem_addr_sel;
    logic [3:0]  rbe;
    logic        bus_err, illegal, ovf_trap;
    logic [31:0] instret;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_instret = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = {state, pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel,
               rd_byte_w_en, bus_err, illegal, ovf_trap, instret};
      n_vec++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL cycle t=%0t op=%h: got st=%0d out=%h instret=%0d, expected st=%0d out=%h instret=%0d",
                 $time, opcode, mon_a.st, mon_a[46:32], mon_a.instret,
                 mon_e.st, mon_e[46:32], mon_e.instret);
      end
    end
  end

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B};
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e = '0;
    e.st = st;
    e.instret = m_instret;
    return e;
  endfunction

  task automatic cyc(input logic rdy, input exp_t e);
    mem_ready = rdy;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic fetch_phase(input int d);
    exp_t e;
    int rem = d;
    while (rem >= TO) begin
      for (int i = 0; i < TO; i++) begin
        e = blank(0); e.mem_req = 1; e.bus_err = (i == TO - 1);
        cyc(0, e);
      end
      rem -= TO;
    end
    for (int i = 0; i < rem; i++) begin
      e = blank(0); e.mem_req = 1; cyc(0, e);
    end
    e = blank(0); e.mem_req = 1; e.ir_we = 1; e.pc_we = 1;
    cyc(1, e);
  endtask

  // Returns 1 when the access completed, 0 when it timed out.
  task automatic mem_phase(input int d, input bit store, output bit done);
    exp_t e;
    int n = (d >= TO) ? TO : d;
    for (int i = 0; i < n; i++) begin
      e = blank(3); e.mem_req = 1; e.mem_addr_sel = 1; e.mem_we = store;
      e.bus_err = (d >= TO) && (i == TO - 1);
      cyc(0, e);
    end
    done = (d < TO);
    if (done) begin
      e = blank(3); e.mem_req = 1; e.mem_addr_sel = 1; e.mem_we = store;
      cyc(1, e);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                           input logic ct, input int fd, input int md);
    exp_t e;
    bit   done;
    opcode = op; funct = fn; overflow = ov; cond_true = ct;
    fetch_phase(fd);
    e = blank(1); e.illegal = !is_legal(op);
    cyc(1'($urandom_range(0, 1)), e);
    if (!is_legal(op)) return;
    e = blank(2);
    if (op == 6'h02) begin e.pc_we = 1; e.pc_src = 2; end
    if (op == 6'h04 || op == 6'h05) begin e.pc_we = ct; e.pc_src = 1; end
    cyc(1'($urandom_range(0, 1)), e);
    if (op inside {6'h02, 6'h04, 6'h05}) begin m_instret++; return; end
    if (op == 6'h23 || op == 6'h2B) begin
      mem_phase(md, op == 6'h2B, done);
      if (!done) return;
      if (op == 6'h2B) begin m_instret++; return; end
    end
    e = blank(4);
    if ((op == 6'h08 || (op == 6'h00 && (fn == 6'h20 || fn == 6'h22))) && ov) e.ovf_trap = 1;
    else e.rbe = 4'b1111;
    cyc(1'($urandom_range(0, 1)), e);
    m_instret++;
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 9))
      0:       return TO - 1;
      1:       return TO;
      2:       return TO + 2;
      default: return $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    logic [5:0] ops [14];
    exp_t e;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0F,
            6'h23, 6'h2B, 6'h23, 6'h2B, 6'h00};
    reset = 1'b0; opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    overflow = 1'b0; cond_true = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin e = '0; cyc(1, e); end
    reset = 1'b1;

    run_instr(6'h00, 6'h20, 0, 0, 0, 0);    // add, no overflow
    run_instr(6'h23, 6'h00, 0, 0, 0, 3);    // lw, memory late by 3
    run_instr(6'h00, 6'h20, 0, 0, TO, 0);   // fetch timeout then refetch
    run_instr(6'h3F, 6'h00, 0, 0, 0, 0);    // illegal opcode
    run_instr(6'h08, 6'h00, 1, 0, 0, 0);    // addi overflow
    run_instr(6'h04, 6'h00, 0, 1, 0, 0);    // beq taken
    run_instr(6'h04, 6'h00, 0, 0, 0, 0);    // beq not taken
    run_instr(6'h2B, 6'h00, 0, 0, TO - 1, TO - 1);  // ready on the timeout cycle
    run_instr(6'h23, 6'h00, 0, 0, 1, TO);   // load abandoned

    // sw with reset asserted mid-MEM
    opcode = 6'h2B; overflow = 0; cond_true = 0;
    fetch_phase(0);
    e = blank(1); cyc(0, e);
    e = blank(2); cyc(0, e);
    for (int i = 0; i < 2; i++) begin
      e = blank(3); e.mem_req = 1; e.mem_addr_sel = 1; e.mem_we = 1; cyc(0, e);
    end
    m_instret = 0;
    sb.push_back('0);
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || instret !== 32'd0 || state !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got mem_req=%b instret=%0d state=%0d, expected 0 0 0",
               mem_req, instret, state);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin e = '0; cyc(1, e); end
    reset = 1'b1;

    for (int i = 0; i < 150; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      fn = $urandom_range(0, 1) ? (($urandom_range(0, 1) != 0) ? 6'h20 : 6'h22) : 6'($urandom);
      run_instr(op, fn, 1'($urandom), 1'($urandom), pick_delay(), pick_delay());
    end

    @(negedge clk); #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips32_mc_ctrl.md
MIPS32_MC_CTRL -- requirements
Module: mips32_mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, legal range 2..255: max cycles a memory request is held without mem_ready.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: IR[31:26] from the instruction register.
REQ-005 SHALL have port funct, input, 6 bits: IR[5:0].
REQ-006 SHALL have port mem_ready, input, 1 bit: memory has completed the current request this cycle.
REQ-007 SHALL have port overflow, input, 1 bit: ALU signed overflow.
REQ-008 SHALL have port cond_true, input, 1 bit: branch condition result from the datapath.
REQ-009 SHALL have port state, output, 3 bits: current FSM state code.
REQ-010 SHALL have port pc_we, output, 1 bit: PC write enable.
REQ-011 SHALL have port pc_src, output, 2 bits: next-PC source (0 = PC+4, 1 = branch target, 2 = jump target).
REQ-012 SHALL have port ir_we, output, 1 bit: instruction register write enable.
REQ-013 SHALL have port mem_req, output, 1 bit: memory request.
REQ-014 SHALL have port mem_we, output, 1 bit: memory write (store).
REQ-015 SHALL have port mem_addr_sel, output, 1 bit: memory address source (0 = PC, 1 = ALU result).
REQ-016 SHALL have port rd_byte_w_en, output, 4 bits: register-file byte write enables.
REQ-017 SHALL have port bus_err, output, 1 bit: one-cycle pulse on memory timeout.
REQ-018 SHALL have port illegal, output, 1 bit: one-cycle pulse on an undecodable opcode.
REQ-019 SHALL have port ovf_trap, output, 1 bit: one-cycle pulse when a writeback is suppressed by overflow.
REQ-020 SHALL have port instret, output, 32 bits: retired-instruction counter.

Function
REQ-021 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-022 SHALL decode the state outputs combinationally from state and inputs; all outputs not listed for a state SHALL be 0.
REQ-023 FETCH SHALL drive mem_req=1 and mem_addr_sel=0.
REQ-024 FETCH with mem_ready=1 SHALL drive ir_we=1, pc_we=1 and pc_src=0, then go to DECODE.
REQ-025 DECODE SHALL go to EXEC for the legal set: opcode 0x00, 0x02, 0x04, 0x05, 0x08-0x0F, 0x23, 0x2B.
REQ-026 DECODE with any other opcode SHALL pulse illegal and go to FETCH, with no write and no instret increment.
REQ-027 EXEC for opcode 0x02 (J) SHALL drive pc_we=1 and pc_src=2, then go to FETCH.
REQ-028 EXEC for opcodes 0x04/0x05 (branch) SHALL drive pc_we=cond_true and pc_src=1, then go to FETCH.
REQ-029 EXEC for opcodes 0x23/0x2B SHALL go to MEM; all other legal opcodes SHALL go to WB.
REQ-030 MEM SHALL drive mem_req=1, mem_addr_sel=1 and mem_we=(opcode==0x2B).
REQ-031 MEM with mem_ready=1 SHALL go to WB for a load and to FETCH for a store.
REQ-032 WB SHALL drive rd_byte_w_en=4'b1111, then go to FETCH.
REQ-033 WB exception: for opcode 0x08, or opcode 0x00 with funct 0x20/0x22, with overflow=1, WB SHALL drive rd_byte_w_en=0 and pulse ovf_trap.
REQ-034 A wait counter SHALL count cycles in FETCH/MEM with mem_ready=0 and SHALL clear on every state change.
REQ-035 When the wait counter equals TIMEOUT-1 and mem_ready=0, the block SHALL pulse bus_err and go to FETCH; mem_req is thus held exactly TIMEOUT cycles.
REQ-036 A FETCH timeout SHALL re-fetch the same PC (no pc_we); a MEM timeout SHALL abandon the instruction with no write and no retire.
REQ-037 mem_ready arriving on the timeout cycle SHALL win: normal completion, no bus_err.
REQ-038 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-039 instret SHALL increment by 1 on each retirement: WB->FETCH (including an ovf_trap writeback), EXEC->FETCH for J/branch, MEM->FETCH for a store.
REQ-040 instret SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-041 While reset=0, the block SHALL hold state=FETCH, the wait counter at 0, instret at 0, and force every other output to 0.
REQ-042 An assertion of reset mid-request SHALL drop mem_req immediately, asynchronously.
REQ-043 After reset deasserts, the first rising edge SHALL begin FETCH with mem_req=1.

Verification
REQ-044 Test R-type add, no overflow, mem_ready on the 1st FETCH cycle: states 0,1,2,4,0; one wb cycle with rd_byte_w_en=1111; instret 0->1.
REQ-045 Test LW with mem_ready delayed 3 cycles in MEM: mem_req=1, mem_addr_sel=1, mem_we=0 for 4 cycles; then WB; instret +1.
REQ-046 Test FETCH with mem_ready held 0 and TIMEOUT=16: mem_req high exactly 16 cycles; bus_err pulses once; state stays 0 with no pc_we; instret unchanged.
REQ-047 Test opcode 0x3F: illegal pulses in DECODE and the next state is FETCH, with no rd_byte_w_en and instret unchanged.
REQ-048 Test addi with overflow=1: WB drives rd_byte_w_en=0000 and ovf_trap=1 for 1 cycle; instret +1.
REQ-049 Test beq with cond_true=1, then with cond_true=0: pc_we is 1 with pc_src=01 in the first case and 0 in the second; reset asserted in MEM of a following SW drops mem_req asynchronously and zeroes instret.
